hub75_scan_ctrl: RTL

//  Scan sequencer for a HUB75 LED panel. Walks rows, bit-planes and columns of the pixel source
//  (framebuffer or test pattern, 1-cycle read latency) via the pixel read interface.

---
 rtl/hub75_scan_ctrl_if.sv | 13 +
 rtl/hub75_scan_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hub75_scan_ctrl_if.sv
// Pixel read bus between the HUB75 scan sequencer (master) and its pixel source (slave).
// The source answers each address with all segment pixels one cycle later.
interface hub75_scan_ctrl_if #(
  parameter int addr_width_p = 12,
  parameter int segments_p   = 2,
  parameter int bpp_p        = 8
);
  logic [addr_width_p-1:0]                  rd_addr;
  logic [segments_p-1:0][2:0][bpp_p-1:0]    rd_data;

  modport master (output rd_addr, input rd_data);
  modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan sequencer: shifts one bit-plane per row into the panel, latches it and
// enables the LEDs for a binary-code-modulated time before moving to the next plane/row.
module hub75_scan_ctrl #(
  parameter int hpixel_p      = 64,
  parameter int vpixel_p      = 64,
  parameter int bpp_p         = 8,
  parameter int segments_p    = 2,
  parameter int base_cycles_p = 4,
  localparam int rows_p       = vpixel_p / segments_p,
  localparam int row_width_p  = (rows_p > 1) ? $clog2(rows_p) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_enable,
  hub75_scan_ctrl_if.master      pix,
  output logic [segments_p-1:0]  o_r,
  output logic [segments_p-1:0]  o_g,
  output logic [segments_p-1:0]  o_b,
  output logic                   o_clk,
  output logic                   o_lat,
  output logic                   o_oe_n,
  output logic [row_width_p-1:0] o_row,
  output logic                   o_frame_done
);

  localparam int addr_width_p  = $clog2(hpixel_p * vpixel_p);
  localparam int col_width_p   = (hpixel_p > 1) ? $clog2(hpixel_p) : 1;
  localparam int plane_width_p = (bpp_p > 1) ? $clog2(bpp_p) : 1;
  localparam int cnt_width_p   = bpp_p + $clog2(base_cycles_p) + 1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CLKOUT,
    LATCH,
    DISPLAY,
    BLANK
  } state_t;

  state_t state, next_state;

  logic [row_width_p-1:0]   row;
  logic [plane_width_p-1:0] plane;
  logic [col_width_p-1:0]   col;
  logic [1:0]               phase;
  logic [cnt_width_p-1:0]   disp_cnt;
  logic [cnt_width_p-1:0]   disp_len;

  logic last_col, last_row, last_plane, disp_done;
  logic oe_n_d, lat_d, clk_d, load_rgb, row_load;
  logic [segments_p-1:0] r_bits, g_bits, b_bits;

  assign last_col   = (col == col_width_p'(hpixel_p - 1));
  assign last_row   = (row == row_width_p'(rows_p - 1));
  assign last_plane = (plane == plane_width_p'(bpp_p - 1));
  assign disp_len   = cnt_width_p'(base_cycles_p) << plane;
  assign disp_done  = (disp_cnt == disp_len - cnt_width_p'(1));

  assign pix.rd_addr = addr_width_p'(row) * addr_width_p'(hpixel_p) + addr_width_p'(col);

  for (genvar s = 0; s < segments_p; s++) begin : g_lane
    assign r_bits[s] = pix.rd_data[s][2][plane];
    assign g_bits[s] = pix.rd_data[s][1][plane];
    assign b_bits[s] = pix.rd_data[s][0][plane];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_enable) next_state = SHIFT;
      SHIFT:   if (phase == 2'd2 && last_col) next_state = CLKOUT;
      CLKOUT:  next_state = LATCH;
      LATCH:   next_state = DISPLAY;
      DISPLAY: if (disp_done) next_state = BLANK;
      BLANK:   next_state = (last_plane && last_row && !i_enable) ? IDLE : SHIFT;
      default: next_state = IDLE;
    endcase
  end

  // Register inputs are computed from the upcoming state so the pins line up with it.
  always_comb begin
    oe_n_d       = (next_state != DISPLAY);
    lat_d        = (next_state == LATCH);
    clk_d        = (state == SHIFT) && (phase == 2'd2);
    load_rgb     = (state == SHIFT) && (phase == 2'd1);
    row_load     = (next_state == LATCH) && (plane == '0);
    o_frame_done = (state == BLANK) && last_plane && last_row;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row      <= '0;
      plane    <= '0;
      col      <= '0;
      phase    <= '0;
      disp_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          row   <= '0;
          plane <= '0;
          col   <= '0;
          phase <= '0;
        end
        SHIFT: begin
          if (phase == 2'd2) begin
            phase <= '0;
            col   <= last_col ? '0 : col + 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        LATCH:   disp_cnt <= '0;
        DISPLAY: disp_cnt <= disp_cnt + 1'b1;
        BLANK: begin
          if (!last_plane) begin
            plane <= plane + 1'b1;
          end else begin
            plane <= '0;
            row   <= last_row ? '0 : row + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The row address only moves at the start of LATCH, while the LEDs are blanked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_r    <= '0;
      o_g    <= '0;
      o_b    <= '0;
      o_clk  <= 1'b0;
      o_lat  <= 1'b0;
      o_oe_n <= 1'b1;
      o_row  <= '0;
    end else begin
      o_clk  <= clk_d;
      o_lat  <= lat_d;
      o_oe_n <= oe_n_d;
      if (load_rgb) begin
        o_r <= r_bits;
        o_g <= g_bits;
        o_b <= b_bits;
      end
      if (row_load) o_row <= row;
    end
  end

endmodule
